// File: rtl/dispense_sequencer.sv
// Motor dispense sequencer: stores one run time per channel, then runs each channel's motor in index order with a dead gap between runs.
// Latency: start sampled at edge E0 drives motor[0] from edge E1; every motor output is registered.
// Flow: loads and start are accepted only in IDLE; abort overrides everything; optional DISPENSE_PAUSE_EN adds a pause input that freezes RUN/GAP timing.
module dispense_sequencer #(
  parameter int NUM_CH    = 3,
  parameter int TIME_W    = 16,
  parameter int TICK_DIV  = 1000,
  parameter int GAP_TICKS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_valid,
  input  logic [$clog2(NUM_CH)-1:0] ld_ch,
  input  logic [TIME_W-1:0]         ld_time,
  input  logic                      start,
  input  logic                      abort,
`ifdef DISPENSE_PAUSE_EN
  input  logic                      pause,
`endif
  output logic [NUM_CH-1:0]         motor,
  output logic [$clog2(NUM_CH)-1:0] cur_ch,
  output logic                      busy,
  output logic                      done
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CH_W1 = CH_W + 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  localparam int TK_W  = (TIME_W > GAP_W) ? TIME_W : GAP_W;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [TK_W-1:0]  GAP_LAST = TK_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]    NUM_CH_V = CH_W1'(NUM_CH);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_RUN, S_GAP, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [CH_W-1:0]     cur_nxt;
  logic [NUM_CH-1:0]   motor_nxt;
  logic [NUM_CH-1:0]   onehot;
  logic [PRE_W-1:0]    pre, pre_nxt, pre_adv;
  logic [TK_W-1:0]     tick, tick_nxt, tick_adv;
  logic [TK_W-1:0]     run_last;
  logic [TIME_W-1:0]   times [NUM_CH];
  logic [TIME_W-1:0]   cur_time;
  logic                paused;
  logic                last_ch;
  logic                run_end;
  logic                gap_end;
  logic                ld_ok;
  state_t              step_state;
  logic [CH_W-1:0]     step_ch;

`ifdef DISPENSE_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign cur_time   = times[cur_ch];
  assign onehot     = {{(NUM_CH-1){1'b0}}, 1'b1} << cur_ch;
  assign last_ch    = (cur_ch == LAST_CH);
  assign ld_ok      = ({1'b0, ld_ch} < NUM_CH_V);
  // Last tick index of a run; only meaningful in RUN, where cur_time is nonzero.
  assign run_last   = TK_W'(cur_time) - TK_W'(1);
  assign run_end    = (pre == PRE_LAST) && (tick == run_last);
  assign gap_end    = (pre == PRE_LAST) && (tick == GAP_LAST);
  assign pre_adv    = (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
  assign tick_adv   = (pre == PRE_LAST) ? tick + TK_W'(1) : tick;
  // After a channel finishes: either the sequence is over or the next channel is selected.
  assign step_state = last_ch ? S_DONE : S_SEL;
  assign step_ch    = last_ch ? cur_ch : cur_ch + CH_W'(1);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  // Register FSM state, channel index, motor enables and the prescaler/tick counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cur_ch <= '0;
      motor  <= '0;
      pre    <= '0;
      tick   <= '0;
    end else begin
      state  <= state_nxt;
      cur_ch <= cur_nxt;
      motor  <= motor_nxt;
      pre    <= pre_nxt;
      tick   <= tick_nxt;
    end
  end

  // Channel time storage: writable only while idle, out-of-range indices dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) times[i] <= '0;
    end else if (state == S_IDLE && ld_valid && ld_ok) begin
      times[ld_ch] <= ld_time;
    end
  end

  // Next-state and next-output decode; abort beats every other transition.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_ch;
    motor_nxt = motor;
    pre_nxt   = pre;
    tick_nxt  = tick;
    if (state != S_IDLE && abort) begin
      state_nxt = S_IDLE;
      cur_nxt   = '0;
      motor_nxt = '0;
      pre_nxt   = '0;
      tick_nxt  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_SEL;
            cur_nxt   = '0;
          end
        end
        S_SEL: begin
          if (cur_time != '0) begin
            state_nxt = S_RUN;
            motor_nxt = onehot;
            pre_nxt   = '0;
            tick_nxt  = '0;
          end else if (last_ch) begin
            state_nxt = S_DONE;
          end else begin
            cur_nxt = cur_ch + CH_W'(1);
          end
        end
        S_RUN: begin
          if (paused) begin
            motor_nxt = '0;
          end else if (run_end) begin
            motor_nxt = '0;
            pre_nxt   = '0;
            tick_nxt  = '0;
            if (GAP_TICKS > 0) begin
              state_nxt = S_GAP;
            end else begin
              state_nxt = step_state;
              cur_nxt   = step_ch;
            end
          end else begin
            motor_nxt = onehot;
            pre_nxt   = pre_adv;
            tick_nxt  = tick_adv;
          end
        end
        S_GAP: begin
          motor_nxt = '0;
          if (!paused) begin
            if (gap_end) begin
              state_nxt = step_state;
              cur_nxt   = step_ch;
              pre_nxt   = '0;
              tick_nxt  = '0;
            end else begin
              pre_nxt  = pre_adv;
              tick_nxt = tick_adv;
            end
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
          cur_nxt   = '0;
          motor_nxt = '0;
        end
        default: begin
          state_nxt = S_IDLE;
          cur_nxt   = '0;
          motor_nxt = '0;
        end
      endcase
    end
  end

endmodule
